serial_frame_receiver: RTL
==========================

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter N, default 4: data bits per frame.
REQ-002 SHALL have parameter ODD, default 0: parity sense (0 = even, 1 = odd).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, 1: serial line; idles high.
REQ-006 SHALL have port data_out, output, N: last accepted word.
REQ-007 SHALL have port valid, output, 1: one-cycle pulse when data_out is updated.
REQ-008 SHALL have port parity_err, output, 1: parity result of the word flagged by valid.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port busy, output, 1: high while a frame is being received.

Function
REQ-011 Frame format SHALL be: start bit 0, then N data bits LSB first, then 1 parity bit, then stop bit 1, with one bit per clk.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-013 IDLE -> DATA SHALL occur on the edge that samples data_in=0; data_in=1 SHALL keep the FSM in IDLE.
REQ-014 DATA SHALL shift in exactly N bits under a bit counter running 0..N-1, then go to PARITY.
REQ-015 PARITY SHALL capture one bit, then go to STOP.
REQ-016 In STOP, a sampled 1 SHALL load data_out with the shifted word, pulse valid for one cycle, and go to IDLE.
REQ-017 parity_err SHALL equal (XOR of data bits ^ parity bit ^ ODD).
REQ-018 parity_err SHALL be valid only while valid=1 and SHALL be low otherwise.
REQ-019 A parity error SHALL still update data_out and pulse valid.
REQ-020 In STOP, a sampled 0 SHALL pulse frame_err for one cycle, leave data_out unchanged, keep valid low, and go to IDLE.
REQ-021 Latency: with the start bit sampled at edge k, valid SHALL be high for the cycle following edge k+N+2.
REQ-022 Back-to-back frames SHALL be supported: a start bit sampled at edge k+N+3 SHALL begin the next frame with no idle bit.
REQ-023 busy SHALL be high in DATA, PARITY and STOP, and low in IDLE.
REQ-024 data_out SHALL hold its value between valid pulses.
REQ-025 Counter wrap: the bit counter SHALL clear on leaving DATA and on reset.
REQ-026 No oversampling or glitch filtering SHALL be performed; the line is synchronous to clk.

Reset
REQ-027 On reset low, the FSM SHALL go to IDLE, and the counter, shift register, data_out, valid, parity_err, frame_err and busy SHALL all go to 0, immediately and asynchronously.
REQ-028 Reset asserted mid-frame SHALL abandon the partial frame with no valid and no frame_err.
REQ-029 After reset release, the first 0 sampled SHALL be treated as a start bit.

Structure
REQ-030 FSM state encodings SHALL be constants in the shared design-examples package/header, reused by the matching framed transmitter.
REQ-031 Data-bit capture SHALL be one sub-module, shift_register_lsb (N-bit, shift-right, serial in at MSB).
REQ-032 Control and parity SHALL remain in the top module.
REQ-033 Target size SHALL be 120-400 lines of RTL.

Verification (N=4, ODD=0)
REQ-034 Frame for 4'hA (line 0,0,1,0,1,0,1): data_out=4'hA, valid pulse at cycle 7 after the start edge, parity_err=0.
REQ-035 Frame for 4'h7 with parity bit 0 (wrong): data_out=4'h7, valid=1, parity_err=1.
REQ-036 Frame for 4'h3 with stop bit 0: frame_err pulses once, valid stays 0, data_out keeps its prior value.
REQ-037 Frames 4'h1 and 4'hE sent back-to-back with no idle: two valid pulses exactly 7 cycles apart, data_out 4'h1 then 4'hE.
REQ-038 Reset low at the third data bit, then release and a clean frame for 4'h5: no output during the aborted frame; data_out=4'h5 with valid.
REQ-039 Line held high for 20 cycles after reset: busy, valid and frame_err stay 0.

Source files
------------

// File: rtl/serial_frame_receiver_pkg.sv
// ============================================================================
// Module   : serial_frame_receiver_pkg
// Brief    : Shared framed-serial FSM state encodings (receiver and transmitter)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_frame_receiver_pkg;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_DATA   = 2'd1;
  localparam logic [1:0] c_ST_PARITY = 2'd2;
  localparam logic [1:0] c_ST_STOP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = c_ST_IDLE,
    DATA   = c_ST_DATA,
    PARITY = c_ST_PARITY,
    STOP   = c_ST_STOP
  } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_frame_receiver_shift_register_lsb.sv
// ============================================================================
// Module   : shift_register_lsb
// Brief    : N-bit shift-right register, serial input enters at the MSB
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_register_lsb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic [N-1:0] data
);

  logic [N-1:0] r_data;

  // After N shifts the first bit received sits in bit 0 (LSB-first line).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (shift_en) begin
      if (N > 1) begin
        r_data <= {serial_in, r_data[N-1:1]};
      end else begin
        r_data <= N'(serial_in);
      end
    end
  end

  assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/serial_frame_receiver.sv
// ============================================================================
// Module   : serial_frame_receiver
// Brief    : Start / N data (LSB first) / parity / stop frame receiver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int N   = 4,
  parameter bit ODD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_in,
  output logic [N-1:0] data_out,
  output logic         valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int              c_CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N - 1);

  frame_state_t       r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_par_bit;
  logic [N-1:0]       w_word;
  logic               w_shift_en;

  assign w_shift_en = (r_state == DATA);

  shift_register_lsb #(
    .N (N)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (w_shift_en),
    .serial_in (data_in),
    .data      (w_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_par_bit  <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!data_in) begin
            r_state <= DATA;
            busy    <= 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= PARITY;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        PARITY: begin
          r_par_bit <= data_in;
          r_state   <= STOP;
        end
        STOP: begin
          // A bad stop bit discards the word; data_out keeps the previous one.
          if (data_in) begin
            data_out   <= w_word;
            valid      <= 1'b1;
            parity_err <= (^w_word) ^ r_par_bit ^ ODD;
          end else begin
            frame_err <= 1'b1;
          end
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
